// File: rtl/count_stimulus.sv
// -----------------------------------------------------------------------------
// count_stimulus
//
// Initiator for the pulse-counting target. A one-cycle `start` (accepted only
// while idle) launches a run. The run issues PULSE_CNT single-cycle `count`
// pulses, with GAP idle cycles between consecutive pulses, and then waits up
// to TIMEOUT cycles for the target's `done`. The verdict (pass / fail /
// early) and the number of pulses issued are held until the next run starts.
//
// Parameters
//   PULSE_CNT  pulses per run                 (1..255)
//   GAP        idle cycles between pulses     (0..255)
//   TIMEOUT    WAIT window after last pulse   (1..255)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   run request, sampled only while idle
//   done         in   completion flag from the target
//   count        out  one-cycle pulse to the target (registered)
//   busy         out  run in progress (PULSE, GAP or WAIT)
//   pass         out  last run saw `done` inside the WAIT window
//   fail         out  last run timed out or saw premature `done`
//   early        out  qualifies `fail`: `done` arrived before the last pulse
//   pulses_sent  out  pulses issued in the current / last run
// -----------------------------------------------------------------------------
module count_stimulus #(
  parameter int PULSE_CNT = 8,
  parameter int GAP       = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  output logic       count,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       early,
  output logic [7:0] pulses_sent
);

  // Out-of-range parameters would let the 8-bit counters wrap; refuse them
  // at elaboration instead of producing a stimulus that silently misbehaves.
  if (PULSE_CNT < 1 || PULSE_CNT > 255 ||
      GAP < 0       || GAP > 255       ||
      TIMEOUT < 1   || TIMEOUT > 255) begin : g_param_check
    $error("count_stimulus: PULSE_CNT, GAP or TIMEOUT out of range");
  end

  // Terminal counter values. GAP_LAST is unused when GAP == 0 because the
  // GAP state is never entered in that configuration.
  localparam logic [7:0] LAST_IDX     = 8'(PULSE_CNT - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t     state;
  logic [7:0] gap_cnt;   // cycles already spent in the current GAP
  logic [7:0] wait_cnt;  // cycles already spent in WAIT

  // Every output is a flop: `count` and `busy` are loaded with the value the
  // next state implies, so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= 1'b0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      early       <= 1'b0;
      pulses_sent <= 8'd0;
      gap_cnt     <= 8'd0;
      wait_cnt    <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in the
      // same edge overrides this default, so `count` is high only on the
      // edges that enter PULSE.
      count <= 1'b0;

      case (state)
        S_IDLE: begin
          // `done` is deliberately ignored here.
          if (start) begin
            state       <= S_PULSE;
            count       <= 1'b1;
            busy        <= 1'b1;
            pass        <= 1'b0;
            fail        <= 1'b0;
            early       <= 1'b0;
            pulses_sent <= 8'd0;
          end
        end

        S_PULSE: begin
          // The pulse being driven this cycle counts even if the run aborts.
          pulses_sent <= pulses_sent + 8'd1;
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            fail  <= 1'b1;
            early <= 1'b1;
          end else if (pulses_sent == LAST_IDX) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd0;
          end else if (GAP == 0) begin
            count <= 1'b1;  // back-to-back pulses, stay in PULSE
          end else begin
            state   <= S_GAP;
            gap_cnt <= 8'd0;
          end
        end

        S_GAP: begin
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            fail  <= 1'b1;
            early <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state <= S_PULSE;
            count <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        S_WAIT: begin
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_stimulus.sv
// -----------------------------------------------------------------------------
// tb_count_stimulus
//
// Three instances of count_stimulus with different parameter sets; one is
// exercised at a time (selected by `sel`). For each run the reference model
// derives, from the run's start cycle and the cycle `done` is raised, the
// cycles on which `count` must pulse and the cycle and verdict of the run's
// end. Those events go into a queue; a monitor on the falling edge pops and
// compares whenever the DUT pulses `count` or drops `busy`.
//
// Cycle n is the clock period that begins at rising edge n (cyc == n).
// Inputs driven during cycle n are sampled at the edge ending it.
// -----------------------------------------------------------------------------
module tb_count_stimulus;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] sel     = 2'd0;
  logic       start_v = 1'b0;
  logic       done_v  = 1'b0;
  logic       mon_en  = 1'b0;

  logic [2:0] start_w, done_w;
  logic [2:0] cnt_w, busy_w, pass_w, fail_w, early_w;
  logic [7:0] ps_w [3];

  assign start_w = start_v ? (3'b001 << sel) : 3'b000;
  assign done_w  = done_v  ? (3'b001 << sel) : 3'b000;

  count_stimulus #(.PULSE_CNT(8), .GAP(1), .TIMEOUT(16)) u_dflt (
    .clk(clk), .rst(rst), .start(start_w[0]), .done(done_w[0]),
    .count(cnt_w[0]), .busy(busy_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
    .early(early_w[0]), .pulses_sent(ps_w[0]));

  count_stimulus #(.PULSE_CNT(4), .GAP(0), .TIMEOUT(16)) u_gap0 (
    .clk(clk), .rst(rst), .start(start_w[1]), .done(done_w[1]),
    .count(cnt_w[1]), .busy(busy_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
    .early(early_w[1]), .pulses_sent(ps_w[1]));

  count_stimulus #(.PULSE_CNT(8), .GAP(1), .TIMEOUT(1)) u_to1 (
    .clk(clk), .rst(rst), .start(start_w[2]), .done(done_w[2]),
    .count(cnt_w[2]), .busy(busy_w[2]), .pass(pass_w[2]), .fail(fail_w[2]),
    .early(early_w[2]), .pulses_sent(ps_w[2]));

  function automatic int p_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction
  function automatic int g_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int t_of(input int i);
    return (i == 2) ? 1 : 16;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit is_end;
    int at;
    bit pass;
    bit fail;
    bit early;
    int pulses;
  } ev_t;

  ev_t exp_q[$];

  // ---------------------------------------------------------------- monitor
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      check("pass_fail_exclusive", {29'd0, pass_w & fail_w}, 32'd0);
      check("idle_instance_count", {29'd0, cnt_w & ~(3'b001 << sel)}, 32'd0);
      if (cnt_w[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_count_cycle", cyc, 32'hFFFF_FFFF);
        end else begin
          ev = exp_q.pop_front();
          check("count_is_pulse", {31'd0, ev.is_end}, 32'd0);
          check("count_cycle", cyc, ev.at);
        end
      end
      if (prev_busy && !busy_w[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end_cycle", cyc, 32'hFFFF_FFFF);
        end else begin
          ev = exp_q.pop_front();
          check("end_is_end", {31'd0, ev.is_end}, 32'd1);
          check("end_cycle", cyc, ev.at);
          check("end_pass", {31'd0, pass_w[sel]}, {31'd0, ev.pass});
          check("end_fail", {31'd0, fail_w[sel]}, {31'd0, ev.fail});
          check("end_early", {31'd0, early_w[sel]}, {31'd0, ev.early});
          check("end_pulses_sent", {24'd0, ps_w[sel]}, ev.pulses);
        end
      end
    end
    prev_busy <= busy_w[sel];
  end

  // ------------------------------------------------------------ run driver
  // dmode: 0 = done never, 1 = done at t0+doff, 2 = done at L+doff,
  //        3 = random. `extra` adds a second start while the run is busy.
  task automatic run(input int dmode, input int doff, input bit extra);
    int p, g, to, t0, last, dc, np, e, xs;
    bit ep, ef, ee;
    ev_t ev;
    p  = p_of(int'(sel));
    g  = g_of(int'(sel));
    to = t_of(int'(sel));
    @(posedge clk); #1;
    t0   = cyc;
    last = t0 + 1 + (p - 1) * (g + 1);
    case (dmode)
      0:       dc = -1;
      1:       dc = t0 + doff;
      2:       dc = last + doff;
      default: dc = ($urandom_range(4) == 0) ? -1
                    : int'($urandom_range(last + to + 3, t0));
    endcase

    // Reference model: classify the single done cycle against the run.
    ep = 1'b0; ef = 1'b0; ee = 1'b0;
    if (dc >= t0 + 1 && dc <= last) begin
      np = (dc - t0 - 1) / (g + 1) + 1;
      e  = dc + 1;
      ef = 1'b1; ee = 1'b1;
    end else if (dc >= last + 1 && dc <= last + to) begin
      np = p;
      e  = dc + 1;
      ep = 1'b1;
    end else begin
      np = p;
      e  = last + to + 1;
      ef = 1'b1;
    end
    xs = extra ? t0 + 1 + int'($urandom_range(e - t0 - 2)) : -1;

    for (int k = 0; k < np; k++) begin
      ev = '{is_end: 1'b0, at: t0 + 1 + k * (g + 1), pass: 1'b0, fail: 1'b0,
             early: 1'b0, pulses: 0};
      exp_q.push_back(ev);
    end
    ev = '{is_end: 1'b1, at: e, pass: ep, fail: ef, early: ee, pulses: np};
    exp_q.push_back(ev);

    while (cyc <= e + 2) begin
      start_v = (cyc == t0) || (cyc == xs);
      done_v  = (dc >= 0) && (cyc == dc);
      @(posedge clk); #1;
    end
    start_v = 1'b0;
    done_v  = 1'b0;

    check("events_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    check("hold_pass", {31'd0, pass_w[sel]}, {31'd0, ep});
    check("hold_fail", {31'd0, fail_w[sel]}, {31'd0, ef});
    check("hold_early", {31'd0, early_w[sel]}, {31'd0, ee});
    check("hold_pulses_sent", {24'd0, ps_w[sel]}, np);
    check("hold_busy", {31'd0, busy_w[sel]}, 32'd0);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int t0;
    ev_t ev;
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", {29'd0, cnt_w}, 32'd0);
    check("reset_busy", {29'd0, busy_w}, 32'd0);
    check("reset_pass", {29'd0, pass_w}, 32'd0);
    check("reset_fail", {29'd0, fail_w}, 32'd0);
    check("reset_early", {29'd0, early_w}, 32'd0);
    check("reset_pulses_sent", {8'd0, ps_w[0], ps_w[1], ps_w[2]}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Defaults: golden target, timeout, premature done in a GAP cycle.
    sel = 2'd0;
    run(2, 2, 1'b0);
    run(0, 0, 1'b0);
    run(1, 6, 1'b0);

    // Asynchronous reset during cycle 8 of a run.
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      ev = '{is_end: 1'b0, at: t0 + 1 + 2 * k, pass: 1'b0, fail: 1'b0,
             early: 1'b0, pulses: 0};
      exp_q.push_back(ev);
    end
    start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    while (cyc < t0 + 8) begin
      @(posedge clk); #1;
    end
    check("pre_reset_pulses_seen", exp_q.size(), 32'd0);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrun_rst_count", {31'd0, cnt_w[0]}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    check("midrun_rst_verdict", {29'd0, pass_w[0], fail_w[0], early_w[0]}, 32'd0);
    check("midrun_rst_pulses_sent", {24'd0, ps_w[0]}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (6) @(posedge clk);  // any count here has no queued event
    run(2, 2, 1'b0);

    for (int i = 0; i < 20; i++) run(3, 0, $urandom_range(1) == 1);

    // PULSE_CNT=4, GAP=0: contiguous pulses, start while busy ignored.
    sel = 2'd1;
    run(2, 2, 1'b1);
    for (int i = 0; i < 15; i++) run(3, 0, $urandom_range(1) == 1);

    // TIMEOUT=1: done at L+1 passes, done at L+2 is a timeout.
    sel = 2'd2;
    run(2, 1, 1'b0);
    run(2, 2, 1'b0);
    for (int i = 0; i < 15; i++) run(3, 0, $urandom_range(1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
